partition_tt_sweeper: RTL
=========================

// Module: partition_tt_sweeper
// PURPOSE
//  - Hardware successor to the per-partition exhaustive truth-table bench: sweeps all 2^N_IN input patterns into an exact partition and its approximate replacement.
//  - Compares the two N_OUT-bit outputs on every pattern and accumulates the error metrics used to accept or reject an approximation.
//  - Sits between the sweep controller and a pair of combinational partition instances; also usable on FPGA for on-chip error characterisation.
// PARAMETERS
//  - N_IN    5  partition input width; the sweep covers 0 .. 2^N_IN-1.
//  - N_OUT   5  partition output width; outputs are compared as unsigned numbers.
//  - SETTLE  1  wait cycles between driving pi_o and sampling outputs (>=0).
// PORTS
//  - clk            in   1                        single clock; all state on rising edge
//  - rst_n          in   1                        reset, asynchronous assert, active-low
//  - start          in   1                        1-cycle request to begin a sweep; honoured only in IDLE or DONE
//  - busy           out  1                        high from the cycle after start accepted until DONE
//  - done           out  1                        level; high in DONE until the next accepted start
//  - pi_o           out  N_IN                     pattern driven to both partitions
//  - po_exact_i     in   N_OUT                    exact partition output
//  - po_approx_i    in   N_OUT                    approximate partition output
//  - err_count      out  N_IN+1                   number of patterns with po_exact_i != po_approx_i
//  - bit_err_count  out  N_IN+$clog2(N_OUT+1)     sum of Hamming distances over all patterns
//  - max_abs_err    out  N_OUT                    max |exact-approx| over all patterns
//  - trc_valid/trc_ready/trc_data  out/in/out 1/1/N_IN+2*N_OUT   present only with SWEEP_TRACE_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, pi_o=0, all counters 0, trc_valid=0.
//  - FSM states:
//    - IDLE --start--> DRIVE. Accepting start clears all counters and sets pi_o=0.
//    - DRIVE: 1 cycle. Goes to SETTLE if SETTLE>0, else to SAMPLE.
//    - SETTLE: SETTLE cycles, then SAMPLE.
//    - SAMPLE: 1 cycle; registers the compare results and updates the metrics.
//    - After SAMPLE: if pi_o == all-ones, go to DONE; otherwise increment pi_o and return to DRIVE.
//    - With tracing enabled, SAMPLE goes to TRACE, which waits for the handshake and then takes the same next step.
//    - DONE --start--> DRIVE, with counters cleared.
//  - Timing without tracing: each pattern takes SETTLE+2 cycles. A sweep takes 2^N_IN*(SETTLE+2) cycles from the accept edge to done=1.
//  - Metric update in SAMPLE:
//    - err_count += (exact != approx).
//    - bit_err_count += popcount(exact ^ approx).
//    - max_abs_err = max(max_abs_err, |exact - approx|), computed in N_OUT+1 bits.
//  - Counters are sized so they cannot overflow: err_count can reach 2^N_IN, bit_err_count can reach 2^N_IN*N_OUT. No saturation logic.
//  - pi_o is stable from DRIVE through SAMPLE and never wraps mid-sweep; the final pattern is all-ones.
//  - start while busy is ignored, with no effect on state or counters.
//  - Results remain readable and stable while done=1.
//  - rst_n low mid-sweep aborts immediately to the reset values; no partial results are retained.
// CONFIGURATION
//  - Macro SWEEP_TRACE_EN.
//  - Defined:
//    - Adds the trc_* ports and the TRACE state.
//    - In TRACE, trc_valid=1 and trc_data={pi_o, exact, approx} (sampled values) are held stable until trc_ready=1.
//    - The transfer completes on the edge where valid&&ready; trc_valid drops on the next cycle unless the next pattern has reached TRACE.
//    - Backpressure stalls the sweep; metrics are unaffected.
//  - Undefined: the trc_* ports and the TRACE state do not exist, and the timing is exactly as stated in BEHAVIOUR.
// STRUCTURE
//  - Package partition_sweep_pkg:
//    - state enum (IDLE, DRIVE, SETTLE, SAMPLE, TRACE, DONE);
//    - width functions for err_count, bit_err_count and the settle counter.
//  - Sub-module hamming_popcount #(W): combinational popcount of exact^approx, reused by any later metric blocks.
//  - Top level: FSM, pattern counter, settle counter, metric registers.
// TESTING (N_IN=5, N_OUT=5, SETTLE=1 unless stated)
//  1. approx==exact==pi -> err_count=0, bit_err_count=0, max_abs_err=0; done rises exactly 96 cycles after start is accepted.
//  2. approx = exact ^ 5'b00001 only when pi=5'b11111 -> err_count=1, bit_err_count=1, max_abs_err=1.
//  3. exact=pi, approx stuck at 0 -> err_count=31, bit_err_count=80, max_abs_err=31.
//  4. Pulse start while busy at pattern 10 -> no restart, results as in case 1. rst_n low at pattern 20 -> all outputs 0, state IDLE.
//  5. SETTLE=0 and SETTLE=3 -> sweep lengths 64 and 160 cycles respectively; results are unchanged.
//  6. SWEEP_TRACE_EN, trc_ready low for 5 cycles on pattern 7 -> trc_data is held stable, exactly 32 transfers occur in order 0..31, and the metrics match the untraced run.

Source files
------------

// File: rtl/partition_sweep_pkg.sv
// Shared types and width helpers for the partition truth-table sweeper.
package partition_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_TRACE,
        ST_DONE
    } sweep_state_t;

    // err_count must be able to hold 2^n_in.
    function automatic int err_count_w(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int bit_err_count_w(input int n_in, input int n_out);
        return n_in + $clog2(n_out + 1);
    endfunction

    function automatic int settle_cnt_w(input int settle);
        return (settle < 2) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/hamming_popcount.sv
// Combinational Hamming distance between two W-bit words.
module hamming_popcount #(
    parameter int W = 5
) (
    input  logic [W-1:0]             a,
    input  logic [W-1:0]             b,
    output logic [$clog2(W+1)-1:0]   count
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0] diff;

    always_comb begin
        diff  = a ^ b;
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(diff[i]);
        end
    end

endmodule

// File: rtl/partition_tt_sweeper.sv
// Exhaustive exact-vs-approximate partition sweeper with error metrics.
// Optional trace stream of every sampled pattern when SWEEP_TRACE_EN is defined.
module partition_tt_sweeper
    import partition_sweep_pkg::*;
#(
    parameter int N_IN   = 5,
    parameter int N_OUT  = 5,
    parameter int SETTLE = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    output logic                                     busy,
    output logic                                     done,
    output logic [N_IN-1:0]                          pi_o,
    input  logic [N_OUT-1:0]                         po_exact_i,
    input  logic [N_OUT-1:0]                         po_approx_i,
`ifdef SWEEP_TRACE_EN
    output logic                                     trc_valid,
    input  logic                                     trc_ready,
    output logic [N_IN+2*N_OUT-1:0]                  trc_data,
`endif
    output logic [err_count_w(N_IN)-1:0]             err_count,
    output logic [bit_err_count_w(N_IN, N_OUT)-1:0] bit_err_count,
    output logic [N_OUT-1:0]                         max_abs_err
);
    localparam int ECW = err_count_w(N_IN);
    localparam int BCW = bit_err_count_w(N_IN, N_OUT);
    localparam int PCW = $clog2(N_OUT + 1);
    localparam int SCW = settle_cnt_w(SETTLE);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'((SETTLE > 0) ? SETTLE - 1 : 0);

    sweep_state_t   state;
    logic [SCW-1:0] settle_cnt;
    logic [PCW-1:0] pop;
    logic [N_OUT:0] diff;
    logic [N_OUT:0] abs_diff;
    logic           last_pattern;

    hamming_popcount #(.W(N_OUT)) u_popcount (
        .a     (po_exact_i),
        .b     (po_approx_i),
        .count (pop)
    );

    // One extra bit so the unsigned difference cannot wrap before taking |.|
    always_comb begin
        diff         = {1'b0, po_exact_i} - {1'b0, po_approx_i};
        abs_diff     = diff[N_OUT] ? (~diff + (N_OUT+1)'(1)) : diff;
        last_pattern = (pi_o == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pi_o          <= '0;
            settle_cnt    <= '0;
            err_count     <= '0;
            bit_err_count <= '0;
            max_abs_err   <= '0;
`ifdef SWEEP_TRACE_EN
            trc_valid     <= 1'b0;
            trc_data      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state         <= ST_DRIVE;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pi_o          <= '0;
                        err_count     <= '0;
                        bit_err_count <= '0;
                        max_abs_err   <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (SETTLE > 0) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end else begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - SCW'(1);
                    end
                end
                ST_SAMPLE: begin
                    err_count     <= err_count + ECW'(po_exact_i != po_approx_i);
                    bit_err_count <= bit_err_count + BCW'(pop);
                    if (abs_diff > {1'b0, max_abs_err}) begin
                        max_abs_err <= abs_diff[N_OUT-1:0];
                    end
`ifdef SWEEP_TRACE_EN
                    state     <= ST_TRACE;
                    trc_valid <= 1'b1;
                    trc_data  <= {pi_o, po_exact_i, po_approx_i};
`else
                    if (last_pattern) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_DRIVE;
                        pi_o  <= pi_o + N_IN'(1);
                    end
`endif
                end
`ifdef SWEEP_TRACE_EN
                ST_TRACE: begin
                    if (trc_ready) begin
                        trc_valid <= 1'b0;
                        if (last_pattern) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DRIVE;
                            pi_o  <= pi_o + N_IN'(1);
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
